lsu: RTL and testbench

//  Load/store unit; consumes the effective address produced by execute (res_o for load/store) and performs the data-memory access.

---
 rtl/lsu.sv | 181 ++++++++++++++++++
 tb/tb_lsu.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit: req/gnt + rvalid data bus, lane steering, load alignment and response timeout.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned H/W accesses finish at once with bus_err_o, no bus access.
module lsu #(
  parameter int RSP_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        load_i,
  input  logic        store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        wb_valid_o,
  output logic [31:0] wb_data_o,
  output logic        done_o,
  output logic        bus_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);
  // state | meaning
  // IDLE  | waiting for a load/store from execute
  // REQ   | mem_req_o held until gnt
  // WAIT  | granted, waiting for rvalid
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam int CW = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RSP_TIMEOUT - 1);
  localparam bit TMO_EN = (RSP_TIMEOUT != 0);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0]   addr_q, wdata_q, wb_q, wb_nxt;
  logic [2:0]    f3_q;
  logic          we_q, err_q, err_nxt;
  logic          accept, misalign, tmo_hit;

  function automatic logic [31:0] align_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = a[1] ? rd[31:16] : rd[15:0];
    // funct3[2] selects the unsigned variants; reserved encodings fall into the word case
    case (f3[1:0])
      2'b00:   align_load = {{24{b[7] & ~f3[2]}}, b};
      2'b01:   align_load = {{16{h[15] & ~f3[2]}}, h};
      default: align_load = rd;
    endcase
  endfunction

  assign accept  = (state == IDLE) && start_i && (load_i || store_i);
  assign tmo_hit = TMO_EN && (cnt == CNT_LAST);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = (funct3_i[1:0] == 2'b01) ? addr_i[0]
                  : (funct3_i[1:0] != 2'b00) && (addr_i[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    err_nxt    = err_q;
    wb_nxt     = wb_q;
    stall_o    = 1'b0;
    mem_req_o  = 1'b0;
    done_o     = 1'b0;
    bus_err_o  = 1'b0;
    wb_valid_o = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall_o   = 1'b1;
          cnt_nxt   = '0;
          err_nxt   = misalign;
          state_nxt = misalign ? DONE : REQ;
        end
      end
      REQ: begin
        stall_o   = 1'b1;
        mem_req_o = 1'b1;
        if (mem_gnt_i) begin
          cnt_nxt = '0;
          if (mem_rvalid_i) begin
            state_nxt = DONE;
            if (!we_q) wb_nxt = align_load(f3_q, addr_q[1:0], mem_rdata_i);
          end else begin
            state_nxt = WAIT;
          end
        end else if (tmo_hit) begin
          state_nxt = DONE;
          err_nxt   = 1'b1;
          if (!we_q) wb_nxt = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WAIT: begin
        stall_o = 1'b1;
        if (mem_rvalid_i) begin
          state_nxt = DONE;
          if (!we_q) wb_nxt = align_load(f3_q, addr_q[1:0], mem_rdata_i);
        end else if (tmo_hit) begin
          state_nxt = DONE;
          err_nxt   = 1'b1;
          if (!we_q) wb_nxt = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE: begin
        done_o     = 1'b1;
        bus_err_o  = err_q;
        wb_valid_o = !we_q && !err_q;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      err_q   <= 1'b0;
      wb_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      err_q <= err_nxt;
      wb_q  <= wb_nxt;
      if (accept) begin
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        f3_q    <= funct3_i;
        we_q    <= store_i;
      end
    end
  end

  always_comb begin
    case (f3_q[1:0])
      2'b00: begin
        mem_be_o    = 4'b0001 << addr_q[1:0];
        mem_wdata_o = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        mem_be_o    = addr_q[1] ? 4'b1100 : 4'b0011;
        mem_wdata_o = {2{wdata_q[15:0]}};
      end
      default: begin
        mem_be_o    = 4'b1111;
        mem_wdata_o = wdata_q;
      end
    endcase
  end

  assign mem_addr_o = {addr_q[31:2], 2'b00};
  assign mem_we_o   = we_q;
  assign wb_data_o  = wb_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: per-transaction timeline model plus per-cycle compare, directed and random traffic.
module tb_lsu;
  localparam int T = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_i = 1'b0, load_i = 1'b0, store_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] addr_i = '0, wdata_i = '0;
  logic        stall_o, wb_valid_o, done_o, bus_err_o, mem_req_o, mem_we_o;
  logic [31:0] wb_data_o, mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  lsu #(.RSP_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .load_i(load_i), .store_i(store_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i), .stall_o(stall_o),
    .wb_valid_o(wb_valid_o), .wb_data_o(wb_data_o), .done_o(done_o), .bus_err_o(bus_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  bit chk_en = 1'b0;
  logic        exp_stall = 0, exp_req = 0, exp_done = 0, exp_err = 0, exp_wbv = 0, exp_we = 0;
  logic [31:0] exp_wb = '0, exp_addr = '0, exp_wdata = '0;
  logic [3:0]  exp_be = '0;
  int          cur_k = -1, obs_done_k = -1;
  logic [3:0]  obs_be = '0;
  logic [31:0] obs_wdata = '0, obs_addr = '0;
  bit          obs_req = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", 32'(stall_o), 32'(exp_stall));
      check("req", 32'(mem_req_o), 32'(exp_req));
      check("done", 32'(done_o), 32'(exp_done));
      check("bus_err", 32'(bus_err_o), 32'(exp_err));
      check("wb_valid", 32'(wb_valid_o), 32'(exp_wbv));
      check("wb_data", wb_data_o, exp_wb);
      if (exp_req) begin
        check("addr", mem_addr_o, exp_addr);
        check("be", 32'(mem_be_o), 32'(exp_be));
        check("we", 32'(mem_we_o), 32'(exp_we));
        check("wdata", mem_wdata_o, exp_wdata);
      end
      if (mem_req_o) begin
        obs_req   = 1'b1;
        obs_be    = mem_be_o;
        obs_wdata = mem_wdata_o;
        obs_addr  = mem_addr_o;
      end
      if (done_o) obs_done_k = cur_k;
    end
  end

  function automatic int size_of(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    int sz = size_of(f3);
    bit sgn = (f3 == 3'd0 || f3 == 3'd1);
    logic [31:0] v;
    int lo = int'(a % 4);
    if (sz == 1) begin
      v = (rd >> (8 * lo)) & 32'hFF;
      if (sgn && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = (rd >> (16 * (lo / 2))) & 32'hFFFF;
      if (sgn && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  task automatic set_idle();
    exp_stall = 0; exp_req = 0; exp_done = 0; exp_err = 0; exp_wbv = 0;
  endtask

  // g = REQ cycles before gnt, r = cycles from gnt to rvalid (0 = same cycle)
  task automatic run_txn(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int g, input int r,
                         input bit poke, input int abort_k);
    int sz = size_of(f3);
    bit misal = 1'b0;
    bit err;
    int d, req_last;
    logic [31:0] lv;
    logic [31:0] lo;
`ifdef LSU_MISALIGN_TRAP_EN
    misal = (sz == 2 && (a % 2) != 0) || (sz == 4 && (a % 4) != 0);
`endif
    obs_req = 1'b0;
    obs_done_k = -1;
    lv = model_load(f3, a, rd);
    if (misal) begin
      d = 1; req_last = 0; err = 1;
    end else if (g >= T) begin
      d = T + 1; req_last = T; err = 1;
    end else begin
      req_last = 1 + g;
      if (r == 0) begin d = 2 + g; err = 0; end
      else if (r > T) begin d = 2 + g + T; err = 1; end
      else begin d = 2 + g + r; err = 0; end
    end
    lo = a % 4;
    exp_addr = a & 32'hFFFF_FFFC;
    exp_we = !ld;
    if (sz == 1) begin
      exp_be = 4'(1 << lo);
      exp_wdata = {4{wd[7:0]}};
    end else if (sz == 2) begin
      exp_be = (lo >= 2) ? 4'b1100 : 4'b0011;
      exp_wdata = {2{wd[15:0]}};
    end else begin
      exp_be = 4'b1111;
      exp_wdata = wd;
    end
    for (int k = 0; k <= d; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        start_i = 1; load_i = ld; store_i = !ld; funct3_i = f3; addr_i = a; wdata_i = wd;
      end else begin
        start_i = (k == d) && poke;
        load_i = 1'($urandom % 2); store_i = !load_i;
        funct3_i = 3'($urandom); addr_i = $urandom; wdata_i = $urandom;
      end
      mem_gnt_i = !misal && g < T && k == 1 + g;
      mem_rvalid_i = !misal && g < T && ((r == 0 && k == 1 + g) || (r > 0 && r <= T && k == 1 + g + r));
      mem_rdata_i = mem_rvalid_i ? rd : $urandom;
      exp_stall = k < d;
      exp_req = !misal && k >= 1 && k <= req_last;
      exp_done = k == d;
      exp_err = (k == d) && err;
      exp_wbv = (k == d) && ld && !err;
      if (k == d && ld && !misal) exp_wb = err ? 32'h0 : lv;
      cur_k = k;
      if (k == abort_k) begin
        reset = 1;
        @(posedge clk); #1;
        reset = 0; start_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
        set_idle();
        exp_wb = '0;
        cur_k = -1;
        return;
      end
    end
  endtask

  task automatic gap(input int n, input bit stray);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      start_i = 1'($urandom % 2); load_i = 0; store_i = 0; addr_i = $urandom;
      mem_gnt_i = stray && ($urandom % 2 == 0);
      mem_rvalid_i = stray && ($urandom % 2 == 0);
      mem_rdata_i = $urandom;
      set_idle();
      cur_k = -1;
    end
  endtask

  initial begin
    @(posedge clk); #1;
    set_idle();
    chk_en = 1;
    repeat (2) begin @(posedge clk); #1; end
    reset = 0;
    check("rst_wb", wb_data_o, 32'h0);
    check("rst_stall", 32'(stall_o), 32'h0);
    gap(2, 1);

    run_txn(0, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 0, 0, 0, -1);
    gap(1, 0);
    check("sw_done_cycle", 32'(obs_done_k), 32'd2);
    check("sw_be", 32'(obs_be), 32'hF);
    check("sw_wdata", obs_wdata, 32'hDEADBEEF);
    check("sw_addr", obs_addr, 32'h104);

    run_txn(1, 3'b000, 32'h203, 32'h0, 32'h80FF_1234, 2, 3, 0, -1);
    gap(1, 0);
    check("lb_wb", wb_data_o, 32'hFFFF_FF80);
    check("lb_be", 32'(obs_be), 32'h8);

    run_txn(1, 3'b101, 32'h202, 32'h0, 32'h9ABC_5678, 1, 1, 1, -1);
    gap(1, 0);
    check("lhu_wb", wb_data_o, 32'h0000_9ABC);
    check("lhu_be", 32'(obs_be), 32'hC);

    run_txn(0, 3'b001, 32'h202, 32'h1234, 32'h0, 0, 2, 0, -1);
    gap(1, 0);
    check("sh_wdata", obs_wdata, 32'h1234_1234);
    check("sh_wb_held", wb_data_o, 32'h0000_9ABC);

    run_txn(1, 3'b010, 32'h100, 32'h0, 32'h5555_5555, 0, 100, 0, -1);
    gap(2, 1);
    check("tmo_done_cycle", 32'(obs_done_k), 32'd10);
    check("tmo_wb", wb_data_o, 32'h0);

    run_txn(1, 3'b010, 32'h102, 32'h0, 32'hCAFE_F00D, 0, 0, 0, -1);
    gap(1, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_req", 32'(obs_req), 32'h0);
    check("mis_done_cycle", 32'(obs_done_k), 32'd1);
`else
    check("mis_addr", obs_addr, 32'h100);
    check("mis_be", 32'(obs_be), 32'hF);
`endif

    run_txn(1, 3'b010, 32'h300, 32'h0, 32'h0, 0, 100, 0, 4);
    gap(3, 1);
    check("abort_wb", wb_data_o, 32'h0);
    check("abort_done_seen", 32'(obs_done_k), 32'hFFFF_FFFF);
    run_txn(1, 3'b010, 32'h300, 32'h0, 32'h1122_3344, 1, 1, 0, -1);
    gap(1, 0);
    check("post_abort_wb", wb_data_o, 32'h1122_3344);

    for (int i = 0; i < 250; i++) begin
      int g, r, ab;
      g  = ($urandom % 10 == 0) ? T + int'($urandom % 2) : int'($urandom % 4);
      r  = ($urandom % 10 == 0) ? T + 1 : (($urandom % 10 == 0) ? T : int'($urandom % 4));
      ab = ($urandom % 20 == 0) ? int'($urandom_range(1, 4)) : -1;
      run_txn(1'($urandom % 2), 3'($urandom), $urandom, $urandom, $urandom, g, r,
              ($urandom % 4 == 0), ab);
      gap(int'($urandom % 3), 1);
    end
    gap(2, 0);
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
